// File: rtl/sim_pkg.sv
// sim_pkg -- shared definitions for the step scheduler slice.
//   state_e              : frame sequencer states
//   DEF_NODE_COUNT       : default nodes per core
//   DEF_CONSTRAINT_ITERS : default constraint passes per frame
//   POS_W                : position word width, also used for the frame counter
package sim_pkg;

  localparam int DEF_NODE_COUNT       = 5;
  localparam int DEF_CONSTRAINT_ITERS = 2;
  localparam int POS_W                = 32;
  localparam int FRAME_W              = POS_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VERLET,
    ST_XCHG,
    ST_CONSTRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/step_scheduler_if.sv
// step_scheduler_if -- control bus between the step scheduler and its host.
//   start, stall, xchg_ack          : host -> scheduler
//   verlet_en, constraint_en        : per-node enables
//   xchg_req, busy, done            : status / handshake back to host
//   iter_count, frame_count         : progress counters
// Modports: master (host side), slave (scheduler side).
interface step_scheduler_if
  import sim_pkg::*;
#(
  parameter int NODE_COUNT       = DEF_NODE_COUNT,
  parameter int CONSTRAINT_ITERS = DEF_CONSTRAINT_ITERS
);

  localparam int ITER_W = $clog2(CONSTRAINT_ITERS + 1);

  logic                  start;
  logic                  stall;
  logic                  xchg_ack;
  logic [NODE_COUNT-1:0] verlet_en;
  logic [NODE_COUNT-1:0] constraint_en;
  logic                  xchg_req;
  logic                  busy;
  logic                  done;
  logic [ITER_W-1:0]     iter_count;
  logic [FRAME_W-1:0]    frame_count;

  modport master (
    output start, stall, xchg_ack,
    input  verlet_en, constraint_en, xchg_req, busy, done, iter_count, frame_count
  );

  modport slave (
    input  start, stall, xchg_ack,
    output verlet_en, constraint_en, xchg_req, busy, done, iter_count, frame_count
  );

endinterface

// File: rtl/onehot_walker.sv
// onehot_walker -- one-hot shift register that selects the node under constraint.
//   clk, reset : clock, asynchronous active-high reset
//   load       : place the token on bit 0
//   advance    : move the token up one bit; advancing from the top bit empties it
//   onehot     : registered one-hot (or zero) node select
//   last       : high while the token sits on bit NODE_COUNT-1
module onehot_walker
  import sim_pkg::*;
#(
  parameter int NODE_COUNT = DEF_NODE_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  output logic [NODE_COUNT-1:0] onehot,
  output logic                  last
);

  logic [NODE_COUNT-1:0] walk_q;
  logic [NODE_COUNT-1:0] walk_d;

  // NOTE: always_comb assigns every output a default first so no path leaves
  // it unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    walk_d = walk_q;
    if (load) begin
      walk_d = {{(NODE_COUNT-1){1'b0}}, 1'b1};
    end else if (advance) begin
      // Shifting out of the top bit leaves zero, which is exactly the
      // "no node selected" value wanted once a pass completes.
      walk_d = walk_q << 1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      walk_q <= '0;
    end else begin
      walk_q <= walk_d;
    end
  end

  assign onehot = walk_q;
  assign last   = walk_q[NODE_COUNT-1];

endmodule

// File: rtl/step_scheduler.sv
// step_scheduler -- per-frame sequencer for a Verlet/constraint physics core.
// A frame runs VERLET (one cycle, all nodes integrate), then CONSTRAINT_ITERS
// passes of XCHG (boundary exchange handshake) followed by a one-hot walk over
// all nodes in CONSTRAIN, and finishes with a one-cycle done pulse.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : step_scheduler_if.slave (start/stall/xchg_ack in; enables,
//                handshake, status and counters out -- all registered)
module step_scheduler
  import sim_pkg::*;
#(
  parameter int NODE_COUNT       = DEF_NODE_COUNT,
  parameter int CONSTRAINT_ITERS = DEF_CONSTRAINT_ITERS
) (
  input logic             clk,
  input logic             reset,
  step_scheduler_if.slave bus
);

  localparam int ITER_W = $clog2(CONSTRAINT_ITERS + 1);

  state_e                state_q, state_d;
  logic [NODE_COUNT-1:0] verlet_q, verlet_d;
  logic                  xchg_req_q, xchg_req_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [FRAME_W-1:0]    frame_count_q, frame_count_d;

  logic                  walk_load;
  logic                  walk_adv;
  logic                  walk_last;
  logic [NODE_COUNT-1:0] walk_onehot;

  onehot_walker #(.NODE_COUNT(NODE_COUNT)) u_walker (
    .clk     (clk),
    .reset   (reset),
    .load    (walk_load),
    .advance (walk_adv),
    .onehot  (walk_onehot),
    .last    (walk_last)
  );

  // Outputs are computed for the *next* state so they can be registered and
  // still line up with the state they belong to.
  always_comb begin
    state_d       = state_q;
    verlet_d      = '0;
    xchg_req_d    = 1'b0;
    done_d        = 1'b0;
    iter_d        = iter_q;
    frame_count_d = frame_count_q;
    walk_load     = 1'b0;
    walk_adv      = 1'b0;

    if (bus.stall) begin
      // Freeze: hold every output flop, walker receives neither load nor advance.
      verlet_d   = verlet_q;
      xchg_req_d = xchg_req_q;
      done_d     = done_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d  = ST_VERLET;
            verlet_d = '1;
            iter_d   = '0;
          end
        end
        ST_VERLET: begin
          state_d    = ST_XCHG;
          xchg_req_d = 1'b1;
        end
        ST_XCHG: begin
          if (bus.xchg_ack) begin
            state_d   = ST_CONSTRAIN;
            walk_load = 1'b1;
          end else begin
            xchg_req_d = 1'b1;
          end
        end
        ST_CONSTRAIN: begin
          walk_adv = 1'b1;
          if (walk_last) begin
            iter_d = iter_q + ITER_W'(1);
            if (int'(iter_q) + 1 < CONSTRAINT_ITERS) begin
              state_d    = ST_XCHG;
              xchg_req_d = 1'b1;
            end else begin
              state_d       = ST_DONE;
              done_d        = 1'b1;
              // Counted on entry to DONE so a stall inside DONE cannot recount.
              frame_count_d = frame_count_q + FRAME_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      verlet_q      <= '0;
      xchg_req_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      iter_q        <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      verlet_q      <= verlet_d;
      xchg_req_q    <= xchg_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      iter_q        <= iter_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.verlet_en     = verlet_q;
  assign bus.constraint_en = walk_onehot;
  assign bus.xchg_req      = xchg_req_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.iter_count    = iter_q;
  assign bus.frame_count   = frame_count_q;

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler -- directed, scoreboard-checked bench for step_scheduler.
// Expected per-cycle output snapshots are queued when a scenario is set up and
// popped one per clock (sampled 1 ns after the rising edge).
module tb_step_scheduler;
  import sim_pkg::*;

  localparam int N      = DEF_NODE_COUNT;
  localparam int ITERS  = DEF_CONSTRAINT_ITERS;
  localparam int ITER_W = $clog2(ITERS + 1);

  typedef struct packed {
    logic [N-1:0]      verlet;
    logic [N-1:0]      cons;
    logic              xreq;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter;
    logic [31:0]       fc;
  } obs_t;

  logic clk = 1'b0;
  logic reset;

  step_scheduler_if #(.NODE_COUNT(N), .CONSTRAINT_ITERS(ITERS)) bus ();

  step_scheduler #(.NODE_COUNT(N), .CONSTRAINT_ITERS(ITERS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  obs_t              exp_q[$];
  int                tests_run    = 0;
  int                tests_failed = 0;
  logic [31:0]       fc_exp;
  logic [ITER_W-1:0] it_exp;

  function automatic obs_t sample();
    obs_t o;
    o.verlet = bus.verlet_en;
    o.cons   = bus.constraint_en;
    o.xreq   = bus.xchg_req;
    o.busy   = bus.busy;
    o.done   = bus.done;
    o.iter   = bus.iter_count;
    o.fc     = bus.frame_count;
    return o;
  endfunction

  function automatic void push(logic [N-1:0] v, logic [N-1:0] c, logic x, logic b, logic d);
    obs_t e;
    e.verlet = v;
    e.cons   = c;
    e.xreq   = x;
    e.busy   = b;
    e.done   = d;
    e.iter   = it_exp;
    e.fc     = fc_exp;
    exp_q.push_back(e);
  endfunction

  function automatic void push_idle(int n);
    for (int i = 0; i < n; i++) push('0, '0, 1'b0, 1'b0, 1'b0);
  endfunction

  // One stall-free frame; w0 extra cycles of withheld ack in the first XCHG.
  function automatic void push_frame(int w0);
    logic [N-1:0] one;
    one    = {{(N-1){1'b0}}, 1'b1};
    it_exp = '0;
    push('1, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < ITERS; i++) begin
      it_exp = ITER_W'(i);
      for (int w = 0; w <= ((i == 0) ? w0 : 0); w++) push('0, '0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < N; k++) push('0, one << k, 1'b0, 1'b1, 1'b0);
    end
    it_exp = ITER_W'(ITERS);
    fc_exp = fc_exp + 32'd1;
    push('0, '0, 1'b0, 1'b1, 1'b1);
  endfunction

  task automatic check(string tag);
    obs_t obs;
    obs_t exp;
    obs = sample();
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: scoreboard empty, got v=%b c=%b", tag, obs.verlet, obs.cons);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        tests_failed++;
        $error("FAIL %s: got v=%b c=%b x=%b b=%b d=%b it=%0d fc=%h, expected v=%b c=%b x=%b b=%b d=%b it=%0d fc=%h",
               tag, obs.verlet, obs.cons, obs.xreq, obs.busy, obs.done, obs.iter, obs.fc,
               exp.verlet, exp.cons, exp.xreq, exp.busy, exp.done, exp.iter, exp.fc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    bus.xchg_ack = 1'b1;
    fc_exp       = '0;
    it_exp       = '0;

    // Reset state.
    #2;
    push_idle(1);
    check("reset_state");
    @(negedge clk);
    reset = 1'b0;
    push_idle(2);
    run("idle_after_reset", 2);

    // Basic frame, ack tied high: done 14 cycles after the start edge.
    push_frame(0);
    push_idle(2);
    bus.start = 1'b1;
    run("basic", 1);
    bus.start = 1'b0;
    run("basic", exp_q.size());

    // Ack withheld for 3 cycles in the first XCHG.
    bus.xchg_ack = 1'b0;
    push_frame(3);
    push_idle(1);
    bus.start = 1'b1;
    run("ack_wait", 1);
    bus.start = 1'b0;
    run("ack_wait", 4);
    bus.xchg_ack = 1'b1;
    run("ack_wait", exp_q.size());

    // start re-pulsed mid-frame (cycle 5) and in DONE (cycle 14) is ignored.
    push_frame(0);
    push_idle(3);
    bus.start = 1'b1;
    run("restart_ignored", 1);
    bus.start = 1'b0;
    run("restart_ignored", 4);
    bus.start = 1'b1;
    run("restart_ignored", 1);
    bus.start = 1'b0;
    run("restart_ignored", 8);
    bus.start = 1'b1;
    run("restart_ignored", 1);
    bus.start = 1'b0;
    run("restart_ignored", exp_q.size());

    // Stall cycles 4-6 in CONSTRAIN, then stall 2 cycles inside DONE.
    push_frame(0);
    for (int k = 0; k < 3; k++) exp_q.insert(3, exp_q[3]);
    for (int k = 0; k < 2; k++) exp_q.insert(16, exp_q[16]);
    push_idle(1);
    bus.start = 1'b1;
    run("stall", 1);
    bus.start = 1'b0;
    run("stall", 3);
    bus.stall = 1'b1;
    run("stall", 3);
    bus.stall = 1'b0;
    run("stall", 10);
    bus.stall = 1'b1;
    run("stall_done", 2);
    bus.stall = 1'b0;
    run("stall_done", exp_q.size());

    // Stall in IDLE blocks start.
    push_idle(3);
    bus.stall = 1'b1;
    bus.start = 1'b1;
    run("stall_idle", 2);
    bus.start = 1'b0;
    bus.stall = 1'b0;
    run("stall_idle", 1);

    // Reset at cycle 10 abandons the frame; a fresh frame then counts from 0.
    push_frame(0);
    bus.start = 1'b1;
    run("pre_reset", 1);
    bus.start = 1'b0;
    run("pre_reset", 9);
    exp_q.delete();
    reset = 1'b1;
    #1;
    fc_exp = '0;
    it_exp = '0;
    push_idle(1);
    check("reset_mid_frame");
    @(negedge clk);
    reset = 1'b0;
    push_idle(3);
    run("after_reset", 3);
    push_frame(0);
    push_idle(1);
    bus.start = 1'b1;
    run("fresh_frame", 1);
    bus.start = 1'b0;
    run("fresh_frame", exp_q.size());

    // frame_count wraps from all-ones to zero.
    force dut.frame_count_q = 32'hFFFF_FFFF;
    fc_exp = 32'hFFFF_FFFF;
    push_idle(1);
    run("fc_forced", 1);
    release dut.frame_count_q;
    push_idle(1);
    run("fc_held", 1);
    push_frame(0);
    push_idle(1);
    bus.start = 1'b1;
    run("fc_wrap", 1);
    bus.start = 1'b0;
    run("fc_wrap", exp_q.size());

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
